// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} rf_state_e;

  // Widest data word the byte-merge helper handles; DATA_W must stay below this.
  localparam int MAX_W  = 256;
  localparam int MAX_BE = MAX_W / 8;

  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_v,
                                                input logic [MAX_W-1:0]  new_v,
                                                input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MAX_BE; k++)
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: zero-register force, then same-cycle write forwarding.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                fwd_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic [DATA_W-1:0]   data
);

  logic [MAX_W-1:0]        merged;
  logic [MAX_W-DATA_W-1:0] unused_hi;
  logic [DATA_W-1:0]       fwd_data;

  assign merged = be_merge(MAX_W'(mem_data), MAX_W'(wr_data), MAX_BE'(wr_be));
  assign {unused_hi, fwd_data} = merged;

  always_comb begin
    data = mem_data;
    if (ZERO_REG != 0 && addr == '0)
      data = '0;
    else if (BYPASS != 0 && fwd_en && addr == wr_addr)
      data = fwd_data;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-masked writes and an init sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic                     wr_ack,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_e         state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              sweep_go, wr_go;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [MAX_W-1:0]        wr_merged;
  logic [MAX_W-DATA_W-1:0] unused_wr_hi;
  logic [DATA_W-1:0]       wr_word;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state  <= INIT;
      ptr    <= '0;
      wr_ack <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      wr_ack <= wr_go;
    end
  end

  // clr_req wins over both the sweep step and a pending write.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sweep_go = 1'b0;
    wr_go    = 1'b0;
    case (state)
      INIT: begin
        if (clr_req) begin
          ptr_nx = '0;
        end else begin
          sweep_go = 1'b1;
          ptr_nx   = ptr + 1'b1;
          if (ptr == '1) state_nx = READY;
        end
      end
      READY: begin
        if (clr_req) begin
          state_nx = INIT;
          ptr_nx   = '0;
        end else begin
          wr_go = wr_en;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  assign busy = (state == INIT);

  assign wr_merged = be_merge(MAX_W'(mem[wr_addr]), MAX_W'(wr_data), MAX_BE'(wr_be));
  assign {unused_wr_hi, wr_word} = wr_merged;

  // Array has no reset; only the sweep gives it defined contents.
  always_ff @(posedge CLK) begin
    if (reset_n) begin
      if (sweep_go)
        mem[ptr] <= DATA_W'(ptr);
      else if (wr_go && !(ZERO_REG != 0 && wr_addr == '0))
        mem[wr_addr] <= wr_word;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .addr    (addr),
      .mem_data(mem[addr]),
      .fwd_en  (wr_go),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_be   (wr_be),
      .data    (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule
